ws2812_multi_tx: RTL and testbench

- Parametrised N-channel WS2812 line driver. It succeeds the single-lane interface and frame-buffer read path under the WS2812 top level.
- It accepts one pixel word per LED index, covering all channels in lockstep, over a valid/ready stream from the frame buffer or data controller.
- It encodes each channel onto its own data line with programmable bit timing, then closes every frame with a latch (reset) low period.

---
 rtl/ws2812_multi_tx_if.sv | 28 ++
 rtl/ws2812_multi_tx.sv | 214 +++++++++++++++++++++
 tb/tb_ws2812_multi_tx.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_multi_tx_if.sv
`default_nettype none
// =============================================================================
// Module  : ws2812_multi_tx_if -- pixel stream from frame buffer to WS2812 driver
// Revision: 1.0
// =============================================================================
interface ws2812_multi_tx_if #(
    parameter int DATA_W = 96
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [15:0]       pix_index;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready,
        input  pix_index
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        output pix_index
    );
endinterface
`default_nettype wire

// File: rtl/ws2812_multi_tx.sv
`default_nettype none
// =============================================================================
// Module  : ws2812_multi_tx -- N-channel lockstep WS2812 encoder with latch gap;
//           define WS_RGB_TO_GRB_EN to reorder RGB source words to GRB on load
// Revision: 1.0
// =============================================================================
module ws2812_multi_tx #(
    parameter int CHANNELS   = 4,
    parameter int COLOR_BITS = 24,
    parameter int BIT_CLKS   = 125,
    parameter int T0H_CLKS   = 40,
    parameter int T1H_CLKS   = 80,
    parameter int RESET_CLKS = 6000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         num_leds,
    input  logic                frame_start,
    output logic                busy,
    output logic                frame_done,
    output logic                underrun,
    ws2812_multi_tx_if.slave    pix,
    output logic [CHANNELS-1:0] data_out
);
    localparam int c_dw = CHANNELS * COLOR_BITS;
    localparam int c_cw = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int c_bw = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int c_lw = $clog2(RESET_CLKS + 1);

    localparam logic [c_cw-1:0] c_clk_last = c_cw'(BIT_CLKS - 1);
    localparam logic [c_cw-1:0] c_t0h      = c_cw'(T0H_CLKS);
    localparam logic [c_cw-1:0] c_t1h      = c_cw'(T1H_CLKS);
    localparam logic [c_bw-1:0] c_bit_last = c_bw'(COLOR_BITS - 1);
    localparam logic [c_lw-1:0] c_lat_last = c_lw'(RESET_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SEND  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;
    logic [15:0]         nl_q, nl_d;
    logic [15:0]         pix_index_q, pix_index_d;
    logic [15:0]         sent_q, sent_d;
    logic                buf_valid_q, buf_valid_d;
    logic [c_dw-1:0]     buf_q, buf_d;
    logic [c_dw-1:0]     shift_q, shift_d;
    logic [c_bw-1:0]     bit_cnt_q, bit_cnt_d;
    logic [c_cw-1:0]     clk_cnt_q, clk_cnt_d;
    logic [c_lw-1:0]     lat_cnt_q, lat_cnt_d;
    logic [CHANNELS-1:0] data_out_q, data_out_d;

    logic                w_ready;
    logic                w_xfer;
    logic [CHANNELS-1:0] w_next_msb;

    function automatic logic [c_dw-1:0] load_word(input logic [c_dw-1:0] w);
`ifdef WS_RGB_TO_GRB_EN
        logic [c_dw-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r[c*COLOR_BITS +: COLOR_BITS] = {w[c*COLOR_BITS+8 +: 8],
                                             w[c*COLOR_BITS+16 +: 8],
                                             w[c*COLOR_BITS +: 8]};
        end
        return r;
`else
        return w;
`endif
    endfunction

    assign w_ready       = busy_q && !buf_valid_q && (pix_index_q < nl_q);
    assign w_xfer        = pix.pix_valid && w_ready;
    assign pix.pix_ready = w_ready;
    assign pix.pix_index = pix_index_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign underrun      = underrun_q;
    assign data_out      = data_out_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_msb
        assign w_next_msb[c] = shift_d[c*COLOR_BITS + COLOR_BITS - 1];
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        nl_d         = nl_q;
        pix_index_d  = pix_index_q;
        sent_d       = sent_q;
        buf_valid_d  = buf_valid_q;
        buf_d        = buf_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        clk_cnt_d    = clk_cnt_q;
        lat_cnt_d    = lat_cnt_q;

        case (state_q)
            S_IDLE: begin
                // frame_done_q marks the cycle the previous frame ends; no restart in it
                if (frame_start && !frame_done_q) begin
                    nl_d        = num_leds;
                    pix_index_d = 16'd0;
                    sent_d      = 16'd0;
                    busy_d      = 1'b1;
                    buf_valid_d = 1'b0;
                    lat_cnt_d   = '0;
                    state_d     = (num_leds == 16'd0) ? S_LATCH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (buf_valid_q) begin
                    shift_d     = load_word(buf_q);
                    buf_valid_d = 1'b0;
                    bit_cnt_d   = '0;
                    clk_cnt_d   = '0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (clk_cnt_q == c_clk_last) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == c_bit_last) begin
                        sent_d    = sent_q + 16'd1;
                        bit_cnt_d = '0;
                        if (sent_d == nl_q) begin
                            state_d   = S_LATCH;
                            lat_cnt_d = '0;
                        end else if (buf_valid_q) begin
                            shift_d     = load_word(buf_q);
                            buf_valid_d = 1'b0;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = S_LATCH;
                            lat_cnt_d  = '0;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (lat_cnt_q == c_lat_last) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new transfer wins over any reload that emptied the buffer this cycle
        if (w_xfer) begin
            buf_valid_d = 1'b1;
            buf_d       = pix.pix_data;
            pix_index_d = pix_index_q + 16'd1;
        end
    end

    // Line level follows the next-cycle counters so data_out lines up with clk_cnt_q
    always_comb begin
        data_out_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            data_out_d[c] = (state_d == S_SEND) &&
                            (clk_cnt_d < (w_next_msb[c] ? c_t1h : c_t0h));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            nl_q         <= 16'd0;
            pix_index_q  <= 16'd0;
            sent_q       <= 16'd0;
            buf_valid_q  <= 1'b0;
            buf_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            clk_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            nl_q         <= nl_d;
            pix_index_q  <= pix_index_d;
            sent_q       <= sent_d;
            buf_valid_q  <= buf_valid_d;
            buf_q        <= buf_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            clk_cnt_q    <= clk_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            data_out_q   <= data_out_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ws2812_multi_tx.sv
`default_nettype none
// =============================================================================
// Module  : tb_ws2812_multi_tx -- line-waveform checks of ws2812_multi_tx
// Revision: 1.0
// =============================================================================
module tb_ws2812_multi_tx;
    localparam int CH       = 2;
    localparam int CB       = 24;
    localparam int BIT      = 10;
    localparam int T0H      = 3;
    localparam int T1H      = 7;
    localparam int RST_CLKS = 20;
    localparam int DW       = CH * CB;
    localparam int MAXP     = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   num_leds;
    logic          frame_start;
    logic          busy, frame_done, underrun;
    logic [CH-1:0] data_out;

    ws2812_multi_tx_if #(.DATA_W(DW)) pix ();

    ws2812_multi_tx #(
        .CHANNELS(CH), .COLOR_BITS(CB), .BIT_CLKS(BIT),
        .T0H_CLKS(T0H), .T1H_CLKS(T1H), .RESET_CLKS(RST_CLKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .num_leds(num_leds), .frame_start(frame_start),
        .busy(busy), .frame_done(frame_done), .underrun(underrun),
        .pix(pix), .data_out(data_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] pix_arr [0:7];

    // Per-frame observations, sampled at negedges
    int rise_t [CH][MAXP];
    int hlen   [CH][MAXP];
    int n_rise [CH];
    int run_len[CH];
    int fd_cnt, fd_t, ur_cnt, ur_t, busy_cyc, first_busy_t;
    int idx_err, rdy_err, busy_err, given;
    bit timeout;

    function automatic logic [CB-1:0] ref_word(input logic [CB-1:0] w);
`ifdef WS_RGB_TO_GRB_EN
        return {w[15:8], w[23:16], w[7:0]};
`else
        return w;
`endif
    endfunction

    function automatic int exp_len(input int c, input int k);
        logic [DW-1:0] p = pix_arr[(k / CB) % 8];
        logic [CB-1:0] w = ref_word(p[c*CB +: CB]);
        return w[CB-1-(k % CB)] ? T1H : T0H;
    endfunction

    function automatic int len_errs(input int npix);
        int e = 0;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < npix * CB && k < n_rise[c] && k < MAXP; k++)
                if (hlen[c][k] != exp_len(c, k)) e++;
        return e;
    endfunction

    // Bit starts must be exactly BIT apart and identical on every channel
    function automatic int gap_errs();
        int e = 0;
        for (int c = 0; c < CH; c++)
            for (int k = 1; k < n_rise[c] && k < MAXP; k++)
                if (rise_t[c][k] - rise_t[c][k-1] != BIT) e++;
        for (int c = 1; c < CH; c++)
            for (int k = 0; k < n_rise[c] && k < n_rise[0] && k < MAXP; k++)
                if (rise_t[c][k] != rise_t[0][k]) e++;
        return e;
    endfunction

    task automatic run_frame(input int n, input int supply, input bit stall, input int fs_again_at);
        int t = 0;
        int budget = n * CB * BIT * 2 + RST_CLKS + 200;
        logic [CH-1:0] prev = '0;
        bit xfer;
        for (int c = 0; c < CH; c++) begin n_rise[c] = 0; run_len[c] = 0; end
        fd_cnt = 0; fd_t = 0; ur_cnt = 0; ur_t = 0; busy_cyc = 0; first_busy_t = -1;
        idx_err = 0; rdy_err = 0; busy_err = 0; given = 0; timeout = 1'b0;
        @(posedge clk); #1;
        num_leds      = 16'(n);
        frame_start   = 1'b1;
        pix.pix_valid = 1'b0;
        while (1) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (data_out[c]) begin
                    if (!prev[c]) begin
                        if (n_rise[c] < MAXP) rise_t[c][n_rise[c]] = t;
                        n_rise[c]++;
                        run_len[c] = 0;
                    end
                    run_len[c]++;
                end else if (prev[c] && n_rise[c] <= MAXP) begin
                    hlen[c][n_rise[c]-1] = run_len[c];
                end
            end
            prev = data_out;
            if (underrun) begin ur_cnt++; ur_t = t; end
            if (t > 0) begin
                if (busy) begin busy_cyc++; if (first_busy_t < 0) first_busy_t = t; end
                if (pix.pix_index !== 16'(given)) idx_err++;
                if (given >= n && pix.pix_ready) rdy_err++;
                if (!busy && !frame_done) busy_err++;
            end
            xfer = pix.pix_valid && pix.pix_ready;
            if (frame_done) begin fd_cnt++; fd_t = t; break; end
            if (t >= budget) begin timeout = 1'b1; break; end
            @(posedge clk); #1;
            frame_start   = (fs_again_at > 0) && (t + 1 == fs_again_at);
            if (xfer) given++;
            pix.pix_valid = (given < supply) && (!stall || $urandom_range(0, 3) != 0);
            pix.pix_data  = pix_arr[given % 8];
            t++;
        end
        pix.pix_valid = 1'b0;
        frame_start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (data_out !== '0)      begin fails++; $display("FAIL reset.data_out: got %0h expected 0", data_out); end
        tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL reset.busy: got %0b expected 0", busy); end
        tests++; if (frame_done !== 1'b0)  begin fails++; $display("FAIL reset.frame_done: got %0b expected 0", frame_done); end
        tests++; if (underrun !== 1'b0)    begin fails++; $display("FAIL reset.underrun: got %0b expected 0", underrun); end
        tests++; if (pix.pix_ready !== 1'b0) begin fails++; $display("FAIL reset.pix_ready: got %0b expected 0", pix.pix_ready); end
        tests++; if (pix.pix_index !== 16'd0) begin fails++; $display("FAIL reset.pix_index: got %0d expected 0", pix.pix_index); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_pixel();
        pix_arr[0] = {24'hFF0000, 24'h000001};
        run_frame(1, 1, 1'b0, 0);
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL single.timeout: got %0b expected 0", timeout); end
        for (int c = 0; c < CH; c++) begin
            tests++; if (n_rise[c] !== CB) begin fails++; $display("FAIL single.bits ch%0d: got %0d expected %0d", c, n_rise[c], CB); end
        end
        tests++; if (len_errs(1) !== 0) begin fails++; $display("FAIL single.pulse_len: got %0d wrong expected 0", len_errs(1)); end
        tests++; if (gap_errs() !== 0)  begin fails++; $display("FAIL single.bit_period: got %0d wrong expected 0", gap_errs()); end
        tests++; if (fd_t - rise_t[0][0] !== CB * BIT + RST_CLKS)
            begin fails++; $display("FAIL single.done_time: got %0d expected %0d", fd_t - rise_t[0][0], CB * BIT + RST_CLKS); end
        tests++; if (ur_cnt !== 0)   begin fails++; $display("FAIL single.underrun: got %0d expected 0", ur_cnt); end
        tests++; if (idx_err !== 0)  begin fails++; $display("FAIL single.pix_index: got %0d wrong expected 0", idx_err); end
        tests++; if (busy_err !== 0) begin fails++; $display("FAIL single.busy: got %0d low cycles expected 0", busy_err); end
    endtask

    task automatic test_random_stream();
        int nl [2] = '{3, 5};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) pix_arr[i] = DW'({$urandom(), $urandom()});
            run_frame(nl[r], nl[r], r == 1, 0);
            tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL stream%0d.timeout: got %0b expected 0", r, timeout); end
            tests++; if (n_rise[0] !== nl[r] * CB) begin fails++; $display("FAIL stream%0d.bits: got %0d expected %0d", r, n_rise[0], nl[r] * CB); end
            tests++; if (len_errs(nl[r]) !== 0) begin fails++; $display("FAIL stream%0d.pulse_len: got %0d wrong expected 0", r, len_errs(nl[r])); end
            tests++; if (gap_errs() !== 0) begin fails++; $display("FAIL stream%0d.contiguous: got %0d wrong expected 0", r, gap_errs()); end
            tests++; if (fd_t - rise_t[0][0] !== nl[r] * CB * BIT + RST_CLKS)
                begin fails++; $display("FAIL stream%0d.done_time: got %0d expected %0d", r, fd_t - rise_t[0][0], nl[r] * CB * BIT + RST_CLKS); end
            tests++; if (given !== nl[r]) begin fails++; $display("FAIL stream%0d.transfers: got %0d expected %0d", r, given, nl[r]); end
            tests++; if (rdy_err !== 0)   begin fails++; $display("FAIL stream%0d.ready_after_last: got %0d expected 0", r, rdy_err); end
            tests++; if (idx_err !== 0)   begin fails++; $display("FAIL stream%0d.pix_index: got %0d wrong expected 0", r, idx_err); end
            tests++; if (ur_cnt !== 0)    begin fails++; $display("FAIL stream%0d.underrun: got %0d expected 0", r, ur_cnt); end
        end
    endtask

    task automatic test_underrun();
        for (int i = 0; i < 8; i++) pix_arr[i] = DW'({$urandom(), $urandom()});
        run_frame(3, 1, 1'b0, 0);
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL underrun.timeout: got %0b expected 0", timeout); end
        tests++; if (ur_cnt !== 1) begin fails++; $display("FAIL underrun.count: got %0d expected 1", ur_cnt); end
        tests++; if (ur_t - rise_t[0][0] !== CB * BIT)
            begin fails++; $display("FAIL underrun.time: got %0d expected %0d", ur_t - rise_t[0][0], CB * BIT); end
        tests++; if (fd_t - ur_t !== RST_CLKS) begin fails++; $display("FAIL underrun.latch_len: got %0d expected %0d", fd_t - ur_t, RST_CLKS); end
        tests++; if (n_rise[0] !== CB) begin fails++; $display("FAIL underrun.bits: got %0d expected %0d", n_rise[0], CB); end
        tests++; if (len_errs(1) !== 0) begin fails++; $display("FAIL underrun.pulse_len: got %0d wrong expected 0", len_errs(1)); end
        tests++; if (fd_cnt !== 1) begin fails++; $display("FAIL underrun.done_count: got %0d expected 1", fd_cnt); end
    endtask

    task automatic test_zero_leds();
        int late_busy = 0;
        run_frame(0, 0, 1'b0, 5);
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL zero.timeout: got %0b expected 0", timeout); end
        tests++; if (n_rise[0] + n_rise[1] !== 0) begin fails++; $display("FAIL zero.bits: got %0d expected 0", n_rise[0] + n_rise[1]); end
        tests++; if (busy_cyc !== RST_CLKS) begin fails++; $display("FAIL zero.busy_len: got %0d expected %0d", busy_cyc, RST_CLKS); end
        tests++; if (fd_t - first_busy_t !== RST_CLKS)
            begin fails++; $display("FAIL zero.done_time: got %0d expected %0d", fd_t - first_busy_t, RST_CLKS); end
        tests++; if (rdy_err !== 0) begin fails++; $display("FAIL zero.pix_ready: got %0d expected 0", rdy_err); end
        // frame_start presented in the frame_done cycle must not start a frame
        frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || frame_done) late_busy++;
        end
        tests++; if (late_busy !== 0) begin fails++; $display("FAIL zero.restart_ignored: got %0d busy cycles expected 0", late_busy); end
    endtask

    task automatic test_reset_mid_bit();
        bit found = 1'b0;
        for (int i = 0; i < 8; i++) pix_arr[i] = DW'({$urandom(), $urandom()});
        @(posedge clk); #1;
        num_leds = 16'd2; frame_start = 1'b1; pix.pix_valid = 1'b1; pix.pix_data = pix_arr[0];
        @(posedge clk); #1 frame_start = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (data_out[0]) begin found = 1'b1; break; end
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL midrst.line_high: got %0b expected 1", found); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++; if (data_out !== '0) begin fails++; $display("FAIL midrst.data_out: got %0h expected 0", data_out); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL midrst.busy: got %0b expected 0", busy); end
        tests++; if (pix.pix_ready !== 1'b0) begin fails++; $display("FAIL midrst.pix_ready: got %0b expected 0", pix.pix_ready); end
        tests++; if (pix.pix_index !== 16'd0) begin fails++; $display("FAIL midrst.pix_index: got %0d expected 0", pix.pix_index); end
        pix.pix_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        pix_arr[0] = DW'({$urandom(), $urandom()});
        run_frame(1, 1, 1'b0, 0);
        tests++; if (n_rise[1] !== CB) begin fails++; $display("FAIL midrst.after_bits: got %0d expected %0d", n_rise[1], CB); end
        tests++; if (len_errs(1) !== 0) begin fails++; $display("FAIL midrst.after_pulse_len: got %0d wrong expected 0", len_errs(1)); end
        tests++; if (fd_t - rise_t[0][0] !== CB * BIT + RST_CLKS)
            begin fails++; $display("FAIL midrst.after_done_time: got %0d expected %0d", fd_t - rise_t[0][0], CB * BIT + RST_CLKS); end
    endtask

`ifdef WS_RGB_TO_GRB_EN
    task automatic test_grb();
        logic [CB-1:0] got;
        pix_arr[0] = {24'h123456, 24'h123456};
        run_frame(1, 1, 1'b0, 0);
        for (int c = 0; c < CH; c++) begin
            got = '0;
            for (int k = 0; k < CB; k++) got[CB-1-k] = (hlen[c][k] == T1H);
            tests++; if (got !== 24'h341256) begin fails++; $display("FAIL grb.ch%0d: got %06h expected 341256", c, got); end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; num_leds = 16'd0; frame_start = 1'b0;
        pix.pix_valid = 1'b0; pix.pix_data = '0;
        test_reset();
        test_single_pixel();
        test_random_stream();
        test_underrun();
        test_zero_leds();
        test_reset_mid_bit();
`ifdef WS_RGB_TO_GRB_EN
        test_grb();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
